// File: rtl/drive_pkg.sv
// Shared types and IR key codes for the drive arbiter and its command slice.
package drive_pkg;

  typedef enum logic [2:0] {
    DIR_STOP   = 3'd0,
    DIR_FWD    = 3'd1,
    DIR_BACK   = 3'd2,
    DIR_LEFT   = 3'd3,
    DIR_RIGHT  = 3'd4,
    DIR_SEARCH = 3'd5
  } dir_t;

  typedef enum logic [1:0] {
    S_STOP        = 2'd0,
    S_MANUAL      = 2'd1,
    S_AUTO_SEARCH = 2'd2,
    S_AUTO_TRACK  = 2'd3
  } mode_t;

  localparam logic [7:0] KEY_FWD   = 8'h02;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_STOP  = 8'h05;
  localparam logic [7:0] KEY_RIGHT = 8'h06;
  localparam logic [7:0] KEY_BACK  = 8'h08;
  localparam logic [7:0] KEY_AUTO  = 8'h0A;

  function automatic logic is_arrow(input logic [7:0] key);
    return (key == KEY_FWD) || (key == KEY_BACK) ||
           (key == KEY_LEFT) || (key == KEY_RIGHT);
  endfunction

  function automatic logic [2:0] key_to_dir(input logic [7:0] key);
    logic [2:0] d;
    case (key)
      KEY_FWD:   d = DIR_FWD;
      KEY_BACK:  d = DIR_BACK;
      KEY_LEFT:  d = DIR_LEFT;
      KEY_RIGHT: d = DIR_RIGHT;
      default:   d = DIR_STOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/drive_cmd_slice.sv
// Valid/ready output register with change coalescing; DRIVE_HEARTBEAT_EN adds a
// periodic forced resend of the current command.
module drive_cmd_slice
  import drive_pkg::*;
`ifdef DRIVE_HEARTBEAT_EN
#(
  parameter int unsigned HEARTBEAT_CYCLES = 5_000_000
)
`endif
(
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [2:0] tgt_dir_i,
  input  logic [1:0] tgt_speed_i,
  input  logic       state_chg_i,
  input  logic       cmd_ready_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_dir_o,
  output logic [1:0] cmd_speed_o
);

  logic       valid_q, valid_d;
  logic [2:0] dir_q, dir_d;
  logic [1:0] speed_q, speed_d;
  logic       dirty_q, dirty_d;
  logic       change;
  logic       accept;
  logic       hb_fire;

  assign accept = valid_q & cmd_ready_i;

`ifdef DRIVE_HEARTBEAT_EN
  localparam int HB_W = $clog2(HEARTBEAT_CYCLES + 1);
  localparam logic [HB_W-1:0] HB_WRAP = HB_W'(HEARTBEAT_CYCLES - 1);
  // Fire one cycle early so the resend is accepted exactly one period after the last one.
  localparam logic [HB_W-1:0] HB_FIRE = HB_W'(HEARTBEAT_CYCLES - 2);

  logic [HB_W-1:0] hb_q, hb_d;

  always_comb begin
    hb_d = hb_q + 1'b1;
    if (accept || (hb_q == HB_WRAP)) begin
      hb_d = '0;
    end
  end

  assign hb_fire = (hb_q == HB_FIRE);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_d;
    end
  end
`else
  assign hb_fire = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    dirty_d = dirty_q;
    change  = state_chg_i || hb_fire ||
              (tgt_dir_i != dir_q) || (tgt_speed_i != speed_q);
    if (valid_q && !cmd_ready_i) begin
      dirty_d = dirty_q | change;
    end else if (dirty_q || change) begin
      valid_d = 1'b1;
      dir_d   = tgt_dir_i;
      speed_d = tgt_speed_i;
      dirty_d = 1'b0;
    end else begin
      valid_d = 1'b0;
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dir_q   <= DIR_STOP;
      speed_q <= 2'd0;
      dirty_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      dirty_q <= dirty_d;
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_dir_o   = dir_q;
  assign cmd_speed_o = speed_q;

endmodule

// File: rtl/drive_arbiter.sv
// Drive mode FSM arbitrating IR keys, camera tracking and mic speed into motor commands.
// DRIVE_HEARTBEAT_EN enables the periodic command resend (HEARTBEAT_CYCLES).
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned MANUAL_TIMEOUT   = 100_000_000,
  parameter int unsigned LOCK_FRAMES      = 3,
  parameter int unsigned LOST_FRAMES      = 5,
`ifdef DRIVE_HEARTBEAT_EN
  parameter int unsigned HEARTBEAT_CYCLES = 5_000_000,
`endif
  parameter logic [1:0]  SEARCH_SPEED     = 2'd1
)(
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       ir_valid,
  input  logic [7:0] ir_button,
  input  logic       cam_valid,
  input  logic [2:0] cam_direction,
  input  logic       orange_detected,
  input  logic [1:0] speed,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_dir,
  output logic [1:0] cmd_speed,
  output logic [1:0] mode
);

  localparam int TMO_W  = $clog2(MANUAL_TIMEOUT + 1);
  localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);
  localparam int LOST_W = $clog2(LOST_FRAMES + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(MANUAL_TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_FRAMES);
  localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_FRAMES);

  mode_t             mode_q, mode_d;
  logic [2:0]        dir_q, dir_d;
  logic [TMO_W-1:0]  timeout_q, timeout_d, timeout_inc;
  logic [LOCK_W-1:0] lock_q, lock_d, lock_inc;
  logic [LOST_W-1:0] lost_q, lost_d, lost_inc;
  logic              ir_trans;
  logic              state_chg;
  logic [2:0]        tgt_dir;
  logic [1:0]        tgt_speed;

  assign timeout_inc = (timeout_q == TMO_MAX) ? timeout_q : timeout_q + 1'b1;
  assign lock_inc    = (lock_q == LOCK_MAX) ? lock_q : lock_q + 1'b1;
  assign lost_inc    = (lost_q == LOST_MAX) ? lost_q : lost_q + 1'b1;

  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    timeout_d = timeout_q;
    lock_d    = lock_q;
    lost_d    = lost_q;
    ir_trans  = 1'b0;

    if (ir_valid) begin
      timeout_d = '0;
      if (ir_button == KEY_STOP) begin
        mode_d   = S_STOP;
        ir_trans = 1'b1;
      end else if (is_arrow(ir_button)) begin
        mode_d   = S_MANUAL;
        dir_d    = key_to_dir(ir_button);
        ir_trans = 1'b1;
      end else if (ir_button == KEY_AUTO) begin
        mode_d   = S_AUTO_SEARCH;
        ir_trans = 1'b1;
      end
    end else if (mode_q == S_MANUAL) begin
      timeout_d = timeout_inc;
      if (timeout_inc == TMO_MAX) begin
        mode_d = S_STOP;
      end
    end

    // A recognised key wins over any camera-driven transition in the same cycle.
    if (cam_valid && !ir_trans) begin
      case (mode_q)
        S_AUTO_SEARCH: begin
          if (orange_detected) begin
            lock_d = lock_inc;
            if (lock_inc == LOCK_MAX) begin
              mode_d = S_AUTO_TRACK;
              dir_d  = cam_direction;
            end
          end else begin
            lock_d = '0;
          end
        end
        S_AUTO_TRACK: begin
          if (orange_detected) begin
            lost_d = '0;
            dir_d  = cam_direction;
          end else begin
            lost_d = lost_inc;
            if (lost_inc == LOST_MAX) begin
              mode_d = S_AUTO_SEARCH;
            end
          end
        end
        default: ;
      endcase
    end

    if (ir_trans || (mode_d != mode_q)) begin
      lock_d = '0;
      lost_d = '0;
    end
  end

  assign state_chg = (mode_d != mode_q);

  // Target is taken from next-state so the command leaves together with the new mode.
  always_comb begin
    tgt_dir   = DIR_STOP;
    tgt_speed = 2'd0;
    case (mode_d)
      S_MANUAL: begin
        tgt_dir   = dir_d;
        tgt_speed = speed;
      end
      S_AUTO_SEARCH: begin
        tgt_dir   = DIR_SEARCH;
        tgt_speed = SEARCH_SPEED;
      end
      S_AUTO_TRACK: begin
        tgt_dir   = dir_d;
        tgt_speed = speed;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= S_STOP;
      dir_q     <= DIR_STOP;
      timeout_q <= '0;
      lock_q    <= '0;
      lost_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      timeout_q <= timeout_d;
      lock_q    <= lock_d;
      lost_q    <= lost_d;
    end
  end

  assign mode = mode_q;

`ifdef DRIVE_HEARTBEAT_EN
  drive_cmd_slice #(.HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)) u_cmd (
`else
  drive_cmd_slice u_cmd (
`endif
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .tgt_dir_i   (tgt_dir),
    .tgt_speed_i (tgt_speed),
    .state_chg_i (state_chg),
    .cmd_ready_i (cmd_ready),
    .cmd_valid_o (cmd_valid),
    .cmd_dir_o   (cmd_dir),
    .cmd_speed_o (cmd_speed)
  );

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Decides the drive mode and produces drive commands for the robot.
- Arbitrates between three requesters:
  - IR remote manual keys (highest priority).
  - Camera orange-tracking direction.
  - Microphone speed level.
- Sits between IR_top_level, classification and mic_top_level on the input side and the motor command link on the output side.
- Emits each new (direction, speed) command over a valid/ready handshake.

Parameters:
- MANUAL_TIMEOUT, 100_000_000: clk_50 cycles without an IR strobe before MANUAL falls back to STOP (2 s).
- LOCK_FRAMES, 3: consecutive camera frames with a target needed to enter AUTO_TRACK.
- LOST_FRAMES, 5: consecutive camera frames without a target needed to drop back to AUTO_SEARCH.
- SEARCH_SPEED, 2'd1: speed code used while searching.
- HEARTBEAT_CYCLES, 5_000_000: resend period (100 ms); used only with DRIVE_HEARTBEAT_EN.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ir_valid  in  1  one-cycle strobe: new IR key decoded.
- ir_button  in  8  IR key code; sampled only when ir_valid=1.
- cam_valid  in  1  one-cycle strobe per camera frame.
- cam_direction  in  3  tracking direction (dir_t); sampled only when cam_valid=1.
- orange_detected  in  1  target present this frame; sampled only when cam_valid=1.
- speed  in  2  microphone speed level, 0..3.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  downstream accepts the command.
- cmd_dir  out  3  commanded direction (dir_t).
- cmd_speed  out  2  commanded speed.
- mode  out  2  current state (mode_t), for HEX/LED display.

Behaviour:
- Reset (asynchronous, immediate):
  - mode=S_STOP, cmd_valid=0, cmd_dir=DIR_STOP, cmd_speed=0.
  - All counters cleared; pending and dirty flags cleared.
  - A handshake in flight when reset asserts is abandoned.
- IR keys, evaluated only on ir_valid:
  - KEY_STOP (8'h05): go to S_STOP from any state.
  - Arrow keys → S_MANUAL from any state, with target dir set:
    - KEY_FWD (8'h02) → DIR_FWD
    - KEY_BACK (8'h08) → DIR_BACK
    - KEY_LEFT (8'h04) → DIR_LEFT
    - KEY_RIGHT (8'h06) → DIR_RIGHT
  - KEY_AUTO (8'h0A): go to S_AUTO_SEARCH from any state.
  - Any other code: ignored, but it still reloads the manual timeout counter.
- Per-state targets and transitions:
  - S_STOP: target is DIR_STOP, speed 0.
  - S_MANUAL:
    - Target is the last arrow key's dir, with speed = live speed input.
    - Timeout counter reloads on every ir_valid.
    - When the counter reaches MANUAL_TIMEOUT, go to S_STOP.
  - S_AUTO_SEARCH:
    - Target is DIR_SEARCH at SEARCH_SPEED.
    - lock_cnt counts consecutive cam_valid frames with orange_detected=1 and clears on a miss frame.
    - When lock_cnt reaches LOCK_FRAMES, go to S_AUTO_TRACK and latch cam_direction from that frame.
  - S_AUTO_TRACK:
    - Target is the latched cam_direction (updated on each hit frame), with speed = live speed input.
    - lost_cnt counts consecutive miss frames and clears on a hit.
    - When lost_cnt reaches LOST_FRAMES, go to S_AUTO_SEARCH.
- Counter rules:
  - lock_cnt and lost_cnt clear on every state entry.
  - Both saturate; neither wraps.
  - Counter width is $clog2(param+1).
- Simultaneous ir_valid and cam_valid:
  - An IR transition overrides any camera transition in the same cycle.
  - If the IR key causes no transition, the camera frame is processed normally.
- Command emission:
  - dirty sets when the target (dir, speed) differs from the last issued command, or when the state changes.
  - If dirty is set at cycle N and no command is pending, cmd_valid=1 at N+1 with the current target.
  - While cmd_valid && !cmd_ready, cmd_dir and cmd_speed hold stable.
  - Target changes during a pending command are coalesced: the latest target is sent next, in the cycle after acceptance.
  - On cmd_valid && cmd_ready, cmd_valid drops next cycle unless dirty is set.
  - With cmd_ready tied high, consecutive target changes produce back-to-back commands.

Optional Feature:
- Macro: DRIVE_HEARTBEAT_EN.
- Defined:
  - A free-running counter forces dirty every HEARTBEAT_CYCLES, so the current command is resent even when unchanged.
  - The counter restarts on every accepted command.
- Undefined: commands are emitted only on change, and the heartbeat counter logic is absent.

Decomposition:
- Package drive_pkg:
  - dir_t enum: DIR_STOP=0, DIR_FWD=1, DIR_BACK=2, DIR_LEFT=3, DIR_RIGHT=4, DIR_SEARCH=5.
  - mode_t enum: S_STOP=0, S_MANUAL=1, S_AUTO_SEARCH=2, S_AUTO_TRACK=3.
  - localparam IR key codes.
- Sub-module drive_cmd_slice holds the valid/ready output register, the dirty/coalesce logic and the optional heartbeat.
- drive_arbiter itself holds the FSM and the frame/timeout counters.

Test Plan (bench overrides MANUAL_TIMEOUT=20, LOCK_FRAMES=3, LOST_FRAMES=5, cmd_ready=1 unless stated):
- Reset release, no stimulus → mode=0; cmd_valid stays 0 for 100 cycles; cmd_dir=0, cmd_speed=0.
- Timeout fall-back:
  - Stimulus: ir_valid with 8'h02, speed=3.
  - Response: one cycle later cmd_valid=1, cmd_dir=1, cmd_speed=3, mode=1.
  - With no further IR, 20 cycles later mode=0 and a command with cmd_dir=0, cmd_speed=0 is issued.
- Lock and loss:
  - Stimulus: KEY_AUTO, then three cam_valid frames with orange=1, dir=3.
  - Response: mode goes 2→3; commands seen are (5, 1) then (3, speed).
  - Then five miss frames → mode=2 and command (5, 1).
  - A hit on the 4th miss frame resets lost_cnt, so mode stays 3.
- Backpressure:
  - Stimulus: cmd_ready=0; arrow keys 02, 04, 06 on consecutive strobes.
  - Response: the first command is held stable at dir=1.
  - After cmd_ready rises, exactly two commands total are accepted: dir=1, then dir=4.
- Simultaneous events:
  - Stimulus: in S_AUTO_SEARCH with lock_cnt=2, ir_valid=KEY_STOP and a cam_valid hit in the same cycle.
  - Response: mode=0; no transition to S_AUTO_TRACK.
- Reset mid-handshake:
  - Stimulus: with cmd_valid=1 and cmd_ready=0, assert rst_n=0.
  - Response: cmd_valid=0 immediately (asynchronous, before the next clock edge).
- DRIVE_HEARTBEAT_EN, HEARTBEAT_CYCLES=50: idle in S_STOP → a (0, 0) command is accepted every 50 cycles.
